// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MEM  = 2'd1,
    UPDATE    = 2'd2,
    FLUSH_ALL = 2'd3
  } state_t;

  // Byte-offset width of a line: word select plus the two byte bits.
  function automatic int off_w(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Round-robin pointer width; a direct-mapped build still keeps one bit.
  function automatic int ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Word-select width; single-word lines keep a tied-off one-bit select.
  function automatic int wsel_w(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 1;
  endfunction

endpackage

// File: rtl/instruction_cache_assoc_if.sv
// CPU fetch port and memory refill port of the instruction cache.
interface instruction_cache_assoc_if
  import icache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  localparam int OFF_W  = off_w(BLOCK_WORDS);
  localparam int LINE_W = 32 * BLOCK_WORDS;

  logic                    READ;
  logic [ADDR_W-1:0]       ADDRESS;
  logic                    FLUSH;
  logic [31:0]             READDATA;
  logic                    BUSYWAIT;
  logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS;
  logic                    MEM_READ;
  logic [LINE_W-1:0]       MEM_READDATA;
  logic                    MEM_BUSYWAIT;
  logic [31:0]             HIT_COUNT;
  logic [31:0]             MISS_COUNT;

  // CPU + memory side (drives requests and refill data)
  modport master (
    output READ, ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_ADDRESS, MEM_READ, HIT_COUNT, MISS_COUNT
  );

  // Cache side
  modport slave (
    input  READ, ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_ADDRESS, MEM_READ, HIT_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/icache_way.sv
// One way of the cache: SETS lines of {valid, tag, data} with a single
// write port and a combinational tag-compare / word-select read side.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int IDX_W       = 3,
  parameter int TAG_W       = 25,
  parameter int BLOCK_WORDS = 4,
  parameter int WSEL_W      = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [TAG_W-1:0]         wtag,
  input  logic [32*BLOCK_WORDS-1:0] wline,
  input  logic [IDX_W-1:0]         ridx,
  input  logic [TAG_W-1:0]         rtag,
  input  logic [WSEL_W-1:0]        rword,
  output logic                     valid,
  output logic                     match,
  output logic [31:0]              word
);
  logic [SETS-1:0]               valid_q;
  logic [TAG_W-1:0]              tag_q  [SETS];
  logic [BLOCK_WORDS-1:0][31:0]  data_q [SETS];
  logic [BLOCK_WORDS-1:0][31:0]  line_rd;

  // Valid bits: global clear beats a same-cycle fill.
  always_ff @(posedge clk) begin
    if (clr)
      valid_q <= '0;
    else if (we)
      valid_q[widx] <= 1'b1;
  end

  // Tag and data arrays carry no reset; only valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wline;
    end
  end

  assign line_rd = data_q[ridx];
  assign valid   = valid_q[ridx];
  assign match   = valid_q[ridx] && (tag_q[ridx] == rtag);

  generate
    if (BLOCK_WORDS > 1) begin : g_multi
      assign word = line_rd[rword];
    end else begin : g_single
      logic unused_rword;
      assign unused_rword = ^rword;
      assign word = line_rd[0];
    end
  endgenerate

endmodule

// File: rtl/instruction_cache_assoc.sv
// N-way set-associative read-only instruction cache: zero-wait hits,
// invalid-first / round-robin refill, deferred whole-cache flush, counters.
module instruction_cache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input logic                      CLK,
  input logic                      RESET_N,
  instruction_cache_assoc_if.slave bus
);
  localparam int OFF_W  = off_w(BLOCK_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 32 * BLOCK_WORDS;
  localparam int BLK_W  = ADDR_W - OFF_W;
  localparam int PTR_W  = ptr_w(WAYS);
  localparam int WSEL_W = wsel_w(BLOCK_WORDS);

  state_t state, nxt;

  logic [TAG_W-1:0]            tag;
  logic [IDX_W-1:0]            idx;
  logic [WSEL_W-1:0]           wsel;
  logic [1:0]                  unused_byte;

  logic [WAYS-1:0]             way_we;
  logic [WAYS-1:0]             way_valid;
  logic [WAYS-1:0]             hit_vec;
  logic [WAYS-1:0][31:0]       way_word;

  logic                        hit;
  logic [31:0]                 hit_word;
  logic [PTR_W-1:0]            vic;
  logic                        vic_by_ptr;

  logic [BLK_W-1:0]            mem_addr_q;
  logic [LINE_W-1:0]           line_q;
  logic [PTR_W-1:0]            vic_q;
  logic                        vic_ptr_q;
  logic [SETS-1:0][PTR_W-1:0]  rr_q;
  logic                        fp_q;
  logic [31:0]                 hit_cnt, miss_cnt;

  logic                        busy, mem_read, hit_go, miss_go, clr_all;
  logic [31:0]                 rdata;

  assign tag         = bus.ADDRESS[ADDR_W-1 -: TAG_W];
  assign idx         = bus.ADDRESS[OFF_W +: IDX_W];
  assign unused_byte = bus.ADDRESS[1:0];

  generate
    if (BLOCK_WORDS > 1) begin : g_wsel
      assign wsel = bus.ADDRESS[OFF_W-1:2];
    end else begin : g_wsel_tie
      assign wsel = '0;
    end
  endgenerate

  // Reset also wipes valid bits, so stale tags never hit afterwards.
  assign clr_all = !RESET_N || (state == FLUSH_ALL);

  icache_way #(
    .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
    .BLOCK_WORDS(BLOCK_WORDS), .WSEL_W(WSEL_W)
  ) u_way [WAYS-1:0] (
    .clk   (CLK),
    .clr   (clr_all),
    .we    (way_we),
    .widx  (mem_addr_q[IDX_W-1:0]),
    .wtag  (mem_addr_q[BLK_W-1 -: TAG_W]),
    .wline (line_q),
    .ridx  (idx),
    .rtag  (tag),
    .rword (wsel),
    .valid (way_valid),
    .match (hit_vec),
    .word  (way_word)
  );

  // Hit select: lowest matching way wins should more than one ever match.
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_word = way_word[w];
      end
    end
  end

  // Victim select: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    vic        = rr_q[idx];
    vic_by_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        vic        = PTR_W'(w);
        vic_by_ptr = 1'b0;
      end
    end
  end

  // Refill write strobe for the registered victim.
  always_comb begin
    way_we = '0;
    for (int w = 0; w < WAYS; w++)
      way_we[w] = (state == UPDATE) && (vic_q == PTR_W'(w));
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next state and CPU/memory outputs; a pending flush outranks a miss.
  always_comb begin
    nxt      = state;
    busy     = bus.READ && !((state == IDLE) && hit && !fp_q);
    rdata    = '0;
    mem_read = 1'b0;
    hit_go   = 1'b0;
    miss_go  = 1'b0;
    if (bus.READ && !busy)
      rdata = hit_word;
    case (state)
      IDLE: begin
        if (fp_q)
          nxt = FLUSH_ALL;
        else if (bus.READ && hit)
          hit_go = 1'b1;
        else if (bus.READ) begin
          miss_go = 1'b1;
          nxt     = READ_MEM;
        end
      end
      READ_MEM: begin
        mem_read = 1'b1;
        if (!bus.MEM_BUSYWAIT)
          nxt = UPDATE;
      end
      UPDATE:    nxt = IDLE;
      FLUSH_ALL: nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Control registers: flush request, miss address/victim, pointers, counters.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fp_q       <= 1'b0;
      mem_addr_q <= '0;
      vic_q      <= '0;
      vic_ptr_q  <= 1'b0;
      rr_q       <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (bus.FLUSH)
        fp_q <= 1'b1;
      else if (state == FLUSH_ALL)
        fp_q <= 1'b0;
      if (hit_go)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss_go) begin
        miss_cnt   <= miss_cnt + 32'd1;
        mem_addr_q <= bus.ADDRESS[ADDR_W-1:OFF_W];
        vic_q      <= vic;
        vic_ptr_q  <= vic_by_ptr;
      end
      if ((state == UPDATE) && vic_ptr_q)
        rr_q[mem_addr_q[IDX_W-1:0]] <= (vic_q == PTR_W'(WAYS - 1)) ? '0 : vic_q + 1'b1;
    end
  end

  // Refill line captured on the edge memory reports done.
  always_ff @(posedge CLK) begin
    if ((state == READ_MEM) && !bus.MEM_BUSYWAIT)
      line_q <= bus.MEM_READDATA;
  end

  assign bus.BUSYWAIT    = busy;
  assign bus.READDATA    = rdata;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = mem_addr_q;
  assign bus.HIT_COUNT   = hit_cnt;
  assign bus.MISS_COUNT  = miss_cnt;

endmodule

// File: doc/instruction_cache_assoc.md
Name: instruction_cache_assoc

Overview:
- Parametrised N-way set-associative, read-only instruction cache between the CPU fetch stage and instruction memory.
- Successor to the direct-mapped 8x16-byte instruction cache. Generalises sets, ways and block size.
- Adds an explicit read request, zero-wait hits, invalid-first/round-robin replacement, a whole-cache FLUSH, and hit/miss counters.

Parameters:
- ADDR_W, 32, byte address width.
- SETS, 8, number of sets; power of two, at least 2.
- WAYS, 2, associativity; one of 1, 2, 4, 8.
- BLOCK_WORDS, 4, 32-bit words per line; power of two, at least 1.
- Derived (localparams, not overridable):
  - OFF_W = log2(BLOCK_WORDS) + 2
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W - IDX_W - OFF_W
  - LINE_W = 32 * BLOCK_WORDS

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- READ  in  1  CPU fetch request.
- ADDRESS  in  ADDR_W  fetch byte address; ADDRESS[1:0] ignored.
- FLUSH  in  1  single-cycle pulse; invalidate all lines.
- READDATA  out  32  instruction word.
- BUSYWAIT  out  1  CPU must hold ADDRESS/READ and stall.
- MEM_ADDRESS  out  ADDR_W-OFF_W  block address to memory.
- MEM_READ  out  1  memory read request.
- MEM_READDATA  in  LINE_W  refill line; word 0 in bits [31:0].
- MEM_BUSYWAIT  in  1  memory not yet done.
- HIT_COUNT  out  32  accepted hits; wraps modulo 2^32.
- MISS_COUNT  out  32  refills started; wraps modulo 2^32.

Behaviour:
- Address split: tag = ADDRESS[ADDR_W-1 -: TAG_W], index = ADDRESS[OFF_W +: IDX_W], word = ADDRESS[OFF_W-1:2].
- HIT (combinational): a way in the indexed set has valid=1 and a matching tag. At most one way may match. Multiple matches are a design error: the bench asserts on them, and the RTL selects the lowest index.
- States:
  - IDLE, READ_MEM, UPDATE (all builds).
  - FLUSH_ALL: only when a flush is pending and the block is in IDLE.
- Reset (RESET_N=0 at a rising edge), including mid-refill:
  - State becomes IDLE; all valid bits 0; all round-robin pointers 0; flush_pending 0; counters 0.
  - MEM_READ = 0 and MEM_ADDRESS = 0 from the next cycle.
  - Tag and data arrays are not cleared.
  - Any memory response still in flight is ignored.
- BUSYWAIT is combinational: READ and not (state == IDLE and HIT and not flush_pending). It is 0 whenever READ = 0.
- READDATA is combinational: the selected word of the hitting way when BUSYWAIT = 0 and READ = 1; otherwise 0. It never carries garbage.
- Hit: zero wait states. HIT_COUNT increments at the edge.
- Miss (IDLE, READ = 1, no hit, no flush pending):
  - Next state READ_MEM; MISS_COUNT increments.
  - The block address {tag, index} is registered into MEM_ADDRESS.
  - The victim way is registered: lowest-index invalid way, else the set's round-robin pointer.
- READ_MEM:
  - MEM_READ = 1 and MEM_ADDRESS is held stable.
  - Exit to UPDATE at the first edge where MEM_BUSYWAIT = 0; MEM_READDATA is captured at that edge.
- UPDATE (one cycle):
  - MEM_READ = 0; the victim's data, tag and valid are written.
  - The set pointer advances to (victim + 1) mod WAYS only if the victim was chosen by the pointer.
  - Next state IDLE; the hit is served the following cycle.
- Miss latency with M memory-busy cycles: BUSYWAIT high for M + 3 cycles. M = 0 gives 3 cycles.
- FLUSH:
  - A pulse in any state sets flush_pending.
  - In IDLE with flush_pending, go to FLUSH_ALL. This takes priority over a miss in the same cycle.
  - FLUSH_ALL clears every valid bit in one cycle, clears flush_pending and returns to IDLE.
  - A flush during a refill is deferred: the refill completes and its line is written, then invalidated.
  - FLUSH and RESET_N = 0 together: reset wins.
- An ADDRESS change while BUSYWAIT = 1 is a protocol violation; the refill uses the registered address.
- READ = 0 in IDLE: no state change; counters are held.

Decomposition:
- Package icache_pkg:
  - State enum: IDLE, READ_MEM, UPDATE, FLUSH_ALL.
  - Functions: clog2-based field widths and word-select.
- Sub-module icache_way, instantiated WAYS times:
  - Storage: SETS x {valid, tag, line}.
  - Write port: write enable, index, tag, line.
  - Global valid-clear input.
  - Read side: combinational match and selected-word outputs.
- Top level: FSM, victim select, round-robin pointers, counters, output muxing.

Test Plan:
- Cold miss (defaults), ADDRESS=0x0000_0040, READ=1, memory busy 2 cycles → MEM_READ high 3 cycles, MEM_ADDRESS=0x0000004, BUSYWAIT high 5 cycles, then READDATA = line word 0; MISS_COUNT=1.
- Same-line hits at 0x44, 0x48, 0x4C after the fill → BUSYWAIT=0 on every cycle, READDATA = words 1, 2, 3; HIT_COUNT=3.
- Conflict with WAYS=2: fill 0x000, 0x080, 0x100 (all index 0) → 0x100 evicts way 0 (0x000). Re-read 0x080 hits; 0x000 misses and evicts way 1.
- FLUSH pulse during READ_MEM of 0x200 → refill completes, one FLUSH_ALL cycle follows, then the re-read of 0x200 misses again; MISS_COUNT=2.
- RESET_N=0 for one cycle mid-READ_MEM → next cycle MEM_READ=0, BUSYWAIT reflects a miss, counters 0; a late MEM_BUSYWAIT=0 writes nothing.
- WAYS=1, SETS=4, BLOCK_WORDS=8 build: addresses 0x000 then 0x080 (same index) → second evicts first; a word-7 read at 0x01C returns bits [255:224].
